// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder slice.
//   - DEFAULT_WIDTH : default operand/result width used by serial_adder.
//   - state_t       : FSM state encoding (IDLE=0, RUN=1, DONE=2).
//                     The unused code 2'd3 is treated as IDLE by the FSM.
//   Optional feature macro used elsewhere in this slice: SERIAL_SUB_EN.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_bit_full_adder.sv
// bit_full_adder
//   One-bit full adder built from two half-adder stages plus an OR on
//   the two half-adder carries.
//   Ports:
//     a, b : operand bits
//     ci   : carry in
//     s    : sum bit      (a ^ b ^ ci)
//     co   : carry out    (majority of a, b, ci)
module bit_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ha1_s;
    logic ha1_c;
    logic ha2_c;

    // First half adder combines the operand bits; the second folds in the carry.
    assign ha1_s = a ^ b;
    assign ha1_c = a & b;
    assign s     = ha1_s ^ ci;
    assign ha2_c = ha1_s & ci;
    assign co    = ha1_c | ha2_c;

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial ripple adder. Adds two WIDTH-bit operands LSB-first, one bit
//   per clock, using a single bit_full_adder and a carry flip-flop.
//   Optional feature macro: SERIAL_SUB_EN (adds the sub port; sub=1 computes
//   a - b by inverting b and forcing the initial carry to 1).
//   Parameters:
//     WIDTH : operand/result width, 2..32
//   Ports:
//     clk   : rising-edge clock
//     rst   : synchronous active-high reset
//     start : request, accepted only when not in RUN
//     a, b  : operands, captured on the accepted-start edge
//     cin   : carry in, captured on the accepted-start edge
//     sub   : subtract select (SERIAL_SUB_EN only)
//     busy  : high while the FSM is in RUN
//     done  : one-cycle pulse when sum/cout are freshly valid
//     sum   : registered result, held until the next completion
//     cout  : registered carry out of the MSB (with sub=1: 1 means no borrow)
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             accept;
    logic             last_bit;
    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] b_load;
    logic             cin_load;

    // A start is honoured in every state except RUN, so the unused encoding
    // behaves like IDLE and DONE can chain straight into the next operation.
    assign accept   = start && (state != ST_RUN);
    assign last_bit = (state == ST_RUN) && (cnt == LAST_CNT);

`ifdef SERIAL_SUB_EN
    // Two's-complement subtract: a + ~b + 1, so cin is ignored when sub=1.
    assign b_load   = sub ? ~b : b;
    assign cin_load = sub ? 1'b1 : cin;
`else
    assign b_load   = b;
    assign cin_load = cin;
`endif

    bit_full_adder u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Next-state logic: RUN lasts exactly WIDTH cycles, DONE lasts one.
    always_comb begin
        state_next = ST_IDLE;
        case (state)
            ST_RUN:  state_next = last_bit ? ST_DONE : ST_RUN;
            default: state_next = start ? ST_RUN : ST_IDLE;
        endcase
    end

    // Datapath and state register. The result registers are written only on
    // the last RUN cycle so observers never see a partially built sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            s_sr   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_sr  <= a;
                b_sr  <= b_load;
                carry <= cin_load;
                cnt   <= '0;
            end else if (state == ST_RUN) begin
                a_sr  <= a_sr >> 1;
                b_sr  <= b_sr >> 1;
                s_sr  <= {fa_s, s_sr[WIDTH-1:1]};
                carry <= fa_co;
                // Wrap to zero on the last bit so cnt never reaches WIDTH.
                cnt   <= last_bit ? '0 : cnt + CNT_W'(1);
                if (last_bit) begin
                    sum_q  <= {fa_s, s_sr[WIDTH-1:1]};
                    cout_q <= fa_co;
                end
            end
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Self-checking bench for serial_adder at WIDTH=8. Expected {cout,sum}
//   values are pushed to a scoreboard queue when an operation is started
//   and popped when the DUT raises done.
//   Define SERIAL_SUB_EN for both bench and RTL to exercise subtraction.
module tb_serial_adder;

    localparam int W     = 8;
    localparam int LIMIT = 4 * W;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub_tb;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int           vectors;
    int           miscompares;
    int           cyc;
    logic [W:0]   exp_q[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_SUB_EN
        .sub   (sub_tb),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: full (W+1)-bit result of the requested operation.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
        logic [W-1:0] yn;
`ifdef SERIAL_SUB_EN
        if (s) begin
            yn = ~y;
            return {1'b0, x} + {1'b0, yn} + {{W{1'b0}}, 1'b1};
        end
`endif
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a one-cycle start; on return the accepting edge has passed.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ci, input logic s);
        a      = x;
        b      = y;
        cin    = ci;
        sub_tb = s;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Counts edges until done is seen, bounded by LIMIT.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < LIMIT) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        logic bad;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_tb = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            vectors++;
            bad = ({busy, done, cout, sum} !== {3'b000, {W{1'b0}}});
            if (bad) begin
                miscompares++;
                $display("[TB] FAIL reset_idle cyc%0d: busy=%b done=%b cout=%b sum=%h, required all 0",
                         i, busy, done, cout, sum);
            end
            tick();
        end
    endtask

    task automatic test_add_basic();
        int         n_busy;
        logic [W:0] e;
        exp_q.push_back(model(8'h3C, 8'h0F, 1'b0, 1'b0));
        start_op(8'h3C, 8'h0F, 1'b0, 1'b0);
        n_busy = 0;
        while (busy && n_busy < LIMIT) begin
            vectors++;
            if ({cout, sum} !== {1'b0, {W{1'b0}}}) begin
                miscompares++;
                $display("[TB] FAIL hold_during_run: got %h, required 000", {cout, sum});
            end
            n_busy++;
            tick();
        end
        vectors++;
        if (n_busy !== W) begin
            miscompares++;
            $display("[TB] FAIL busy_length: got %0d cycles, required %0d", n_busy, W);
        end
        vectors++;
        e = exp_q.pop_front();
        if (done !== 1'b1 || {cout, sum} !== e) begin
            miscompares++;
            $display("[TB] FAIL add_3c_0f: done=%b got %h, required done=1 %h", done, {cout, sum}, e);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL done_pulse_width: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        int         n;
        logic [W:0] e;
        exp_q.push_back(model(8'hFF, 8'h01, 1'b0, 1'b0));
        start_op(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done(n);
        vectors++;
        e = exp_q.pop_front();
        if (done !== 1'b1 || {cout, sum} !== e) begin
            miscompares++;
            $display("[TB] FAIL add_ff_01: done=%b got %h, required done=1 %h", done, {cout, sum}, e);
        end
        // Restart while DONE is showing; the FSM must go straight to RUN.
        exp_q.push_back(model(8'hFF, 8'hFF, 1'b1, 1'b0));
        start_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_no_bubble: busy=%b, required 1", busy);
        end
        wait_done(n);
        vectors++;
        e = exp_q.pop_front();
        if (done !== 1'b1 || n !== W || {cout, sum} !== e) begin
            miscompares++;
            $display("[TB] FAIL add_ff_ff_1: done=%b n=%0d got %h, required done=1 n=%0d %h",
                     done, n, {cout, sum}, W, e);
        end
        tick();
    endtask

    task automatic test_ignore_and_abort();
        int         n;
        logic [W:0] e;
        logic       saw_done;
        exp_q.push_back(model(8'h10, 8'h20, 1'b0, 1'b0));
        start_op(8'h10, 8'h20, 1'b0, 1'b0);
        tick();
        tick();
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        wait_done(n);
        vectors++;
        e = exp_q.pop_front();
        if (done !== 1'b1 || {cout, sum} !== e) begin
            miscompares++;
            $display("[TB] FAIL ignore_midrun: done=%b got %h, required done=1 %h", done, {cout, sum}, e);
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midrun_start_dropped: busy=%b, required 0", busy);
        end
        // Abort on the 4th RUN cycle of a new operation.
        start_op(8'h55, 8'h22, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({busy, done, cout, sum} !== {3'b000, {W{1'b0}}}) begin
            miscompares++;
            $display("[TB] FAIL abort_state: busy=%b done=%b cout=%b sum=%h, required all 0",
                     busy, done, cout, sum);
        end
        saw_done = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            saw_done |= done | busy;
            tick();
        end
        vectors++;
        if (saw_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL abort_no_done: activity=%b, required 0", saw_done);
        end
        // Reset wins over a simultaneous start.
        a = 8'h01; b = 8'h01; start = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_priority: busy=%b, required 0", busy);
        end
    endtask

`ifdef SERIAL_SUB_EN
    task automatic test_sub();
        int         n;
        logic [W:0] e;
        logic [W:0] req[2];
        logic [W-1:0] xa[2];
        logic [W-1:0] xb[2];
        xa[0] = 8'h05; xb[0] = 8'h07; req[0] = 9'h0FE;
        xa[1] = 8'h07; xb[1] = 8'h05; req[1] = 9'h102;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(model(xa[i], xb[i], 1'b0, 1'b1));
            start_op(xa[i], xb[i], 1'b0, 1'b1);
            wait_done(n);
            vectors++;
            e = exp_q.pop_front();
            if (done !== 1'b1 || {cout, sum} !== e || e !== req[i]) begin
                miscompares++;
                $display("[TB] FAIL sub_%0d: done=%b got %h, required done=1 %h", i, done, {cout, sum}, req[i]);
            end
            tick();
        end
    endtask
`endif

    task automatic test_random();
        int         n;
        int         last_done;
        logic [W:0] e;
        logic       s;
        last_done = 0;
        for (int i = 0; i < 1000; i++) begin
            if (i == 0 || $urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) tick();
`ifdef SERIAL_SUB_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom_range(0, 1));
            exp_q.push_back(model(a, b, cin, s));
            start_op(a, b, cin, s);
            wait_done(n);
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL rand_%0d: scoreboard empty", i);
            end else begin
                e = exp_q.pop_front();
                if (done !== 1'b1 || {cout, sum} !== e) begin
                    miscompares++;
                    $display("[TB] FAIL rand_%0d: done=%b got %h, required done=1 %h",
                             i, done, {cout, sum}, e);
                end
            end
            if (i > 0) begin
                vectors++;
                if (cyc - last_done < W + 1) begin
                    miscompares++;
                    $display("[TB] FAIL done_spacing_%0d: got %0d, required >= %0d",
                             i, cyc - last_done, W + 1);
                end
            end
            last_done = cyc;
        end
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_add_basic();
        test_back_to_back();
        test_ignore_and_abort();
`ifdef SERIAL_SUB_EN
        test_sub();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
